// File: rtl/obj_linebuf_pp.sv
// Double-banked sprite line buffer: one bank takes sprite slices with priority/collision
// handling while the other is scanned out to the display and cleared behind the read.
module obj_linebuf_pp #(
    parameter int PIX_W  = 4,
    parameter int ADDR_W = 8,
    parameter int SPR_W  = 16
) (
    input  logic              clkm_48MHZ,
    input  logic              reset,
    input  logic              pix_ce,
    input  logic              line_start,
    input  logic              wr_start,
    input  logic [ADDR_W-1:0] wr_x,
    input  logic [PIX_W-1:0]  wr_pix,
    input  logic              hinv,
    output logic              wr_req,
    output logic [PIX_W-1:0]  ob,
    output logic              hitob,
    output logic              bank
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPR_W - 1);

    typedef enum logic {
        IDLE,
        DRAW
    } state_t;

    state_t state, next_state;

    logic [PIX_W-1:0]  mem [0:2*DEPTH-1];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_ptr_eff;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] clr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              hinv_q;
    logic              hinv_eff;
    logic              rd_bank;
    logic              clr_busy;
    logic [PIX_W-1:0]  d_pix;
    logic              pix_proc;
    logic              pix_nz;
    logic              d_nz;
    logic              collide;
    logic              do_write;

    // A line_start in the same cycle already steers the read to the freshly swapped bank.
    always_comb begin
        rd_ptr_eff = line_start ? '0 : rd_ptr;
        hinv_eff   = line_start ? hinv : hinv_q;
        rd_bank    = line_start ? bank : ~bank;
        rd_addr    = hinv_eff ? ~rd_ptr_eff : rd_ptr_eff;
    end

    always_comb begin
        d_pix    = mem[{bank, wr_ptr}];
        pix_proc = (state == DRAW) && pix_ce && !line_start && !wr_start && !clr_busy;
        pix_nz   = |wr_pix[PIX_W-2:0];
        d_nz     = |d_pix[PIX_W-2:0];
        collide  = pix_proc && pix_nz && d_nz;
        do_write = pix_proc && pix_nz && (!d_nz || (wr_pix[PIX_W-1] && !d_pix[PIX_W-1]));
    end

    always_comb begin
        next_state = state;
        if (wr_start)
            next_state = DRAW;
        else if (line_start)
            next_state = IDLE;
        else if (pix_proc && (cnt == CNT_LAST))
            next_state = IDLE;
    end

    assign wr_req = (state == DRAW);

    always_ff @(posedge clkm_48MHZ or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bank     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            hinv_q   <= 1'b0;
            ob       <= '0;
            hitob    <= 1'b0;
            clr_busy <= 1'b1;
            clr_ptr  <= '0;
        end else begin
            state <= next_state;
            if (line_start) begin
                bank   <= ~bank;
                hinv_q <= hinv;
            end
            if (wr_start) begin
                wr_ptr <= wr_x;
                cnt    <= '0;
            end else if (pix_proc) begin
                wr_ptr <= wr_ptr + 1'b1;
                cnt    <= cnt + 1'b1;
            end
            if (pix_ce) begin
                ob     <= mem[{rd_bank, rd_addr}];
                rd_ptr <= rd_ptr_eff + 1'b1;
                hitob  <= collide;
            end else if (line_start) begin
                rd_ptr <= '0;
            end
            if (clr_busy) begin
                clr_ptr <= clr_ptr + 1'b1;
                if (clr_ptr == '1)
                    clr_busy <= 1'b0;
            end
        end
    end

    // The post-reset sweep zeroes both banks in parallel and overrides normal traffic.
    always_ff @(posedge clkm_48MHZ) begin
        if (clr_busy) begin
            mem[{1'b0, clr_ptr}] <= '0;
            mem[{1'b1, clr_ptr}] <= '0;
        end else begin
            if (do_write)
                mem[{bank, wr_ptr}] <= wr_pix;
            if (pix_ce)
                mem[{rd_bank, rd_addr}] <= '0;
        end
    end

endmodule
